// File: rtl/vend_pkg.sv
// vend_pkg: shared definitions for the vending controller.
//   state_t  - controller FSM state encoding
//   ERR_*    - err_code values reported to the host
//   CREDIT_W - width of the credit accumulator and item prices
package vend_pkg;

    localparam int CREDIT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_WAIT  = 3'd1,
        S_CHECK    = 3'd2,
        S_COLLECT  = 3'd3,
        S_DISPENSE = 3'd4,
        S_CHANGE   = 3'd5
    } state_t;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_SOLD_OUT = 2'd1;
    localparam logic [1:0] ERR_CANCEL   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

endpackage

// File: rtl/vend_credit_acc.sv
// vend_credit_acc: saturating credit register plus idle-cycle timeout counter.
//   clr_i        - zero the credit (new selection / after refund)
//   run_i        - controller is collecting coins; enables the timeout counter
//   add_i/coin_i - add a coin value, saturating at all-ones
//   sub_i/price_i- deduct the item price when dispensing
//   credit_o     - registered credit
//   credit_nxt_o - credit value being written this cycle (used for refund amount)
//   tmo_o        - this cycle is the last allowed idle cycle
module vend_credit_acc
    import vend_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_i,
    input  logic                run_i,
    input  logic                add_i,
    input  logic [7:0]          coin_i,
    input  logic                sub_i,
    input  logic [CREDIT_W-1:0] price_i,
    output logic [CREDIT_W-1:0] credit_o,
    output logic [CREDIT_W-1:0] credit_nxt_o,
    output logic                tmo_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W:0]   sum;
    logic [TW-1:0]       tmo_q, tmo_d;

    always_comb begin
        sum      = {1'b0, credit_q} + {{(CREDIT_W + 1 - 8){1'b0}}, coin_i};
        credit_d = credit_q;
        if (clr_i)
            credit_d = '0;
        else if (sub_i)
            credit_d = credit_q - price_i;
        else if (add_i)
            credit_d = sum[CREDIT_W] ? '1 : sum[CREDIT_W-1:0];

        // Counts consecutive coin-free collect cycles; any coin restarts it.
        tmo_d = '0;
        if (run_i && !add_i && !clr_i)
            tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= '0;
            tmo_q    <= '0;
        end else begin
            credit_q <= credit_d;
            tmo_q    <= tmo_d;
        end
    end

    assign credit_o     = credit_q;
    assign credit_nxt_o = credit_d;
    assign tmo_o        = run_i && !add_i && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/vend_controller.sv
// vend_controller: single-item vending transaction controller.
//   item_sel_valid/item_sel      - customer selection (accepted in IDLE only)
//   coin_valid/coin_value        - coin insertion; refused outside COLLECT
//   cancel                       - customer abort while collecting
//   mem_raddr                    - item_memory read address (1-cycle latency)
//   mem_item_price/avail_count   - item_memory read data
//   mem_dispense_valid/index     - stock decrement request
//   dispense_done                - product released pulse
//   change_valid/change_amount   - refund pulse
//   coin_reject                  - refused coin pulse
//   busy                         - transaction in progress
//   err_code                     - status of the last transaction
module vend_controller
    import vend_pkg::*;
#(
    parameter int  MAX_ITEMS      = 1024,
    parameter int  TIMEOUT_CYCLES = 1000,
    localparam int ADDR_WIDTH     = $clog2(MAX_ITEMS)
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  item_sel_valid,
    input  logic [ADDR_WIDTH-1:0] item_sel,
    input  logic                  coin_valid,
    input  logic [7:0]            coin_value,
    input  logic                  cancel,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [15:0]           mem_item_price,
    input  logic [7:0]            mem_avail_count,
    output logic                  mem_dispense_valid,
    output logic [ADDR_WIDTH-1:0] mem_dispense_index,
    output logic                  dispense_done,
    output logic                  change_valid,
    output logic [15:0]           change_amount,
    output logic                  coin_reject,
    output logic                  busy,
    output logic [1:0]            err_code
);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [CREDIT_W-1:0]   price_q;
    logic [1:0]            err_q;
    logic                  disp_q, done_q, chg_v_q, rej_q;
    logic [CREDIT_W-1:0]   chg_amt_q;

    logic [CREDIT_W-1:0]   credit, credit_nxt;
    logic                  tmo_hit;
    logic                  acc_clr, acc_run, acc_add, acc_sub;

    // Credit is cleared on a new selection and once the refund has been issued.
    assign acc_clr = ((state_q == S_IDLE) && item_sel_valid) || (state_q == S_CHANGE);
    assign acc_run = (state_q == S_COLLECT);
    assign acc_add = acc_run && coin_valid;
    assign acc_sub = (state_q == S_DISPENSE);

    vend_credit_acc #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_acc (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (acc_clr),
        .run_i        (acc_run),
        .add_i        (acc_add),
        .coin_i       (coin_value),
        .sub_i        (acc_sub),
        .price_i      (price_q),
        .credit_o     (credit),
        .credit_nxt_o (credit_nxt),
        .tmo_o        (tmo_hit)
    );

    // Pulses are registered on entry to the state that owns them, so the
    // refund amount is taken from the credit value being written this cycle
    // (includes a same-cycle coin on cancel, or the post-dispense remainder).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            price_q   <= '0;
            err_q     <= ERR_OK;
            disp_q    <= 1'b0;
            done_q    <= 1'b0;
            chg_v_q   <= 1'b0;
            chg_amt_q <= '0;
            rej_q     <= 1'b0;
        end else begin
            disp_q    <= 1'b0;
            done_q    <= 1'b0;
            chg_v_q   <= 1'b0;
            chg_amt_q <= '0;
            rej_q     <= coin_valid && (state_q != S_COLLECT);
            case (state_q)
                S_IDLE: begin
                    if (item_sel_valid) begin
                        idx_q   <= item_sel;
                        err_q   <= ERR_OK;
                        state_q <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: state_q <= S_CHECK;
                S_CHECK: begin
                    if (mem_avail_count == 8'd0) begin
                        err_q   <= ERR_SOLD_OUT;
                        state_q <= S_IDLE;
                    end else begin
                        price_q <= mem_item_price;
                        state_q <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    // cancel outranks a completed payment in the same cycle
                    if (cancel) begin
                        err_q     <= ERR_CANCEL;
                        chg_v_q   <= (credit_nxt != '0);
                        chg_amt_q <= credit_nxt;
                        state_q   <= S_CHANGE;
                    end else if (credit >= price_q) begin
                        disp_q  <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_DISPENSE;
                    end else if (tmo_hit) begin
                        err_q     <= ERR_TIMEOUT;
                        chg_v_q   <= (credit_nxt != '0);
                        chg_amt_q <= credit_nxt;
                        state_q   <= S_CHANGE;
                    end
                end
                S_DISPENSE: begin
                    chg_v_q   <= (credit_nxt != '0);
                    chg_amt_q <= credit_nxt;
                    state_q   <= S_CHANGE;
                end
                S_CHANGE: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_raddr          = idx_q;
    assign mem_dispense_valid = disp_q;
    assign mem_dispense_index = disp_q ? idx_q : '0;
    assign dispense_done      = done_q;
    assign change_valid       = chg_v_q;
    assign change_amount      = chg_amt_q;
    assign coin_reject        = rej_q;
    assign busy               = (state_q != S_IDLE);
    assign err_code           = err_q;

endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: randomized + directed transactions against a
// transaction-level reference model; a negedge monitor pops expected
// dispense / change / reject events from queues as the DUT presents them.
module tb_vend_controller;

    localparam int NI  = 16;
    localparam int AW  = 4;
    localparam int TMO = 8;

    logic          clk, rst_n;
    logic          item_sel_valid, coin_valid, cancel;
    logic [AW-1:0] item_sel, mem_raddr, mem_dispense_index;
    logic [7:0]    coin_value, mem_avail_count;
    logic [15:0]   mem_item_price, change_amount;
    logic          mem_dispense_valid, dispense_done, change_valid, coin_reject, busy;
    logic [1:0]    err_code;

    vend_controller #(.MAX_ITEMS(NI), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .item_sel_valid(item_sel_valid), .item_sel(item_sel),
        .coin_valid(coin_valid), .coin_value(coin_value), .cancel(cancel),
        .mem_raddr(mem_raddr), .mem_item_price(mem_item_price), .mem_avail_count(mem_avail_count),
        .mem_dispense_valid(mem_dispense_valid), .mem_dispense_index(mem_dispense_index),
        .dispense_done(dispense_done), .change_valid(change_valid), .change_amount(change_amount),
        .coin_reject(coin_reject), .busy(busy), .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // item memory (bench-owned), loaded from init_* while mem_load is high
    logic        mem_load;
    logic [15:0] init_price [NI];
    logic [7:0]  init_cnt   [NI];
    logic [15:0] mem_price  [NI];
    logic [7:0]  mem_cnt    [NI];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < NI; i++) begin
                mem_price[i] <= init_price[i];
                mem_cnt[i]   <= init_cnt[i];
            end
        end else begin
            mem_item_price  <= mem_price[mem_raddr];
            mem_avail_count <= mem_cnt[mem_raddr];
            if (mem_dispense_valid && mem_cnt[mem_dispense_index] != 8'd0)
                mem_cnt[mem_dispense_index] <= mem_cnt[mem_dispense_index] - 8'd1;
        end
    end

    // reference model state
    int m_price [NI];
    int m_cnt   [NI];
    int q_disp[$];
    int q_chg[$];
    int q_rej[$];

    // per-collect-cycle stimulus plan
    bit plan_v   [300];
    int plan_val [300];
    bit plan_can [300];
    int plan_len;

    wire [2*AW+22:0] all_outs = {mem_raddr, mem_dispense_valid, mem_dispense_index, dispense_done,
                                 change_valid, change_amount, coin_reject, busy, err_code};

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // monitor
    always @(negedge clk) begin
        if (rst_n && !mem_load) begin
            if (mem_dispense_valid) begin
                if (q_disp.size() == 0) chk("unexpected_dispense", 1, 0);
                else chk("dispense_index", mem_dispense_index, q_disp.pop_front());
                chk("dispense_done_with_valid", dispense_done, 1);
            end else if (dispense_done) begin
                chk("dispense_done_without_valid", 1, 0);
            end
            if (change_valid) begin
                if (q_chg.size() == 0) chk("unexpected_change", change_amount, 0);
                else chk("change_amount", change_amount, q_chg.pop_front());
            end else if (change_amount != 16'd0) begin
                chk("change_amount_idle", change_amount, 0);
            end
            if (coin_reject) begin
                if (q_rej.size() == 0) chk("unexpected_coin_reject", 1, 0);
                else void'(q_rej.pop_front());
            end
        end
    end

    task automatic clear_plan();
        for (int k = 0; k < 300; k++) begin
            plan_v[k] = 0; plan_val[k] = 0; plan_can[k] = 0;
        end
        plan_len = 0;
    endtask

    task automatic random_plan();
        int coins [7] = '{1, 5, 10, 20, 25, 50, 100};
        clear_plan();
        plan_len = $urandom_range(1, 12);
        for (int k = 0; k < plan_len; k++) begin
            plan_v[k]   = ($urandom_range(0, 9) < 6);
            plan_val[k] = coins[$urandom_range(0, 6)];
        end
        if ($urandom_range(0, 3) == 0) plan_can[$urandom_range(0, plan_len - 1)] = 1;
    endtask

    // One transaction: model computes outcome from the rules, then drive it.
    task automatic run_txn(input int idx, input bit rd_coin, input string tag);
        int p, credit, nc, idle, k_exit, e_err;
        bit cv, cn;
        p = m_price[idx];
        k_exit = -1;
        e_err = 0;
        if (m_cnt[idx] == 0) begin
            e_err = 1;
        end else begin
            credit = 0; idle = 0;
            for (int k = 0; k < 300; k++) begin
                cv = (k < plan_len) ? plan_v[k] : 1'b0;
                cn = (k < plan_len) ? plan_can[k] : 1'b0;
                nc = cv ? credit + plan_val[k] : credit;
                if (nc > 65535) nc = 65535;
                if (cn) begin
                    e_err = 2; if (nc != 0) q_chg.push_back(nc); k_exit = k; break;
                end
                if (credit >= p) begin
                    e_err = 0; q_disp.push_back(idx); m_cnt[idx]--;
                    if (nc - p != 0) q_chg.push_back(nc - p);
                    k_exit = k; break;
                end
                idle = cv ? 0 : idle + 1;
                if (idle == TMO) begin
                    e_err = 3; if (nc != 0) q_chg.push_back(nc); k_exit = k; break;
                end
                credit = nc;
            end
        end

        item_sel_valid = 1; item_sel = AW'(idx);
        step();
        item_sel_valid = 0;
        if (rd_coin) begin
            coin_valid = 1; coin_value = 8'd9; q_rej.push_back(1);
        end
        step();
        coin_valid = 0;
        step();
        if (k_exit < 0) chk({tag, "_soldout_busy_low"}, busy, 0);
        for (int k = 0; k <= k_exit; k++) begin
            coin_valid = (k < plan_len) ? plan_v[k] : 1'b0;
            coin_value = 8'(plan_val[k]);
            cancel     = (k < plan_len) ? plan_can[k] : 1'b0;
            step();
            if (k == 0 && p == 0 && k_exit == 0) chk({tag, "_zero_price_latency"}, mem_dispense_valid, 1);
        end
        coin_valid = 0; cancel = 0; coin_value = 0;
        for (int i = 0; i < 10 && busy; i++) step();
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_err_code"}, err_code, e_err);
        chk({tag, "_pending_events"}, q_disp.size() + q_chg.size() + q_rej.size(), 0);
        q_disp.delete(); q_chg.delete(); q_rej.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n = 0; item_sel_valid = 0; item_sel = 0; coin_valid = 0; coin_value = 0; cancel = 0;
        mem_load = 1;
        for (int i = 0; i < NI; i++) begin
            init_price[i] = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(5, 120));
            init_cnt[i]   = 8'($urandom_range(0, 3));
        end
        init_price[3] = 16'd40;    init_cnt[3] = 8'd5;
        init_price[7] = 16'd30;    init_cnt[7] = 8'd0;
        init_price[2] = 16'd0;     init_cnt[2] = 8'd2;
        init_price[5] = 16'hFFFF;  init_cnt[5] = 8'd1;
        for (int i = 0; i < NI; i++) begin
            m_price[i] = init_price[i]; m_cnt[i] = init_cnt[i];
        end
        step(); step();
        chk("reset_outputs", all_outs, 0);
        mem_load = 0; rst_n = 1;
        step();

        // exact payment
        clear_plan(); plan_len = 2;
        plan_v[0] = 1; plan_val[0] = 20; plan_v[1] = 1; plan_val[1] = 20;
        run_txn(3, 0, "exact");
        // overpay, change 10
        clear_plan(); plan_len = 2;
        plan_v[0] = 1; plan_val[0] = 25; plan_v[1] = 1; plan_val[1] = 25;
        run_txn(3, 0, "overpay");
        // sold out
        clear_plan();
        run_txn(7, 0, "soldout");
        // cancel with same-cycle coin
        clear_plan(); plan_len = 2;
        plan_v[0] = 1; plan_val[0] = 20; plan_v[1] = 1; plan_val[1] = 5; plan_can[1] = 1;
        run_txn(3, 0, "cancel");
        // timeout refund
        clear_plan(); plan_len = 1;
        plan_v[0] = 1; plan_val[0] = 10;
        run_txn(3, 0, "timeout");
        // zero price, 4-cycle latency
        clear_plan();
        run_txn(2, 0, "zeroprice");
        // credit saturation then cancel
        clear_plan(); plan_len = 263;
        for (int k = 0; k < 263; k++) begin plan_v[k] = 1; plan_val[k] = 250; end
        plan_can[262] = 1;
        run_txn(5, 0, "saturate");

        // coin in IDLE
        coin_valid = 1; coin_value = 8'd50; q_rej.push_back(1);
        step();
        coin_valid = 0;
        step();
        chk("idle_coin_reject_seen", q_rej.size(), 0);
        q_rej.delete();

        for (int t = 0; t < 30; t++) begin
            random_plan();
            run_txn($urandom_range(0, NI - 1), ($urandom_range(0, 3) == 0), "rand");
        end

        // reset mid-COLLECT: credit discarded, no pulses
        m_cnt[3] = m_cnt[3];
        item_sel_valid = 1; item_sel = 4'd3;
        step();
        item_sel_valid = 0;
        step(); step();
        coin_valid = 1; coin_value = 8'd20;
        step();
        coin_valid = 0;
        step();
        rst_n = 0;
        #2;
        chk("reset_mid_collect_outputs", all_outs, 0);
        step();
        rst_n = 1;
        for (int i = 0; i < 5; i++) step();
        chk("after_reset_busy", busy, 0);

        clear_plan(); plan_len = 1;
        plan_v[0] = 1; plan_val[0] = 100;
        run_txn(3, 0, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
